// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage MIPS core.
// Tracks the producer of each in-flight instruction through E/M/W in shadow registers
// and derives the D-stage stall/bubble plus the D, E and M forwarding-mux selects.
module hazard_ctrl #(
    parameter int unsigned TW = 2,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] d_r_new,
    input  logic [RW-1:0] d_r_use1,
    input  logic [RW-1:0] d_r_use2,
    input  logic [TW-1:0] d_t_new,
    input  logic [TW-1:0] d_t_use1,
    input  logic [TW-1:0] d_t_use2,
    input  logic          d_md,
    input  logic          d_md_start,
    input  logic          md_busy,
    output logic          stall,
    output logic          flush_e,
    output logic [1:0]    fwd_d1,
    output logic [1:0]    fwd_d2,
    output logic [1:0]    fwd_e1,
    output logic [1:0]    fwd_e2,
    output logic          fwd_m2
);

    // Shadow copies of the producer/consumer info for the instructions in E, M and W.
    logic [RW-1:0] e_r_new, e_r_use1, e_r_use2;
    logic [TW-1:0] e_t_new;
    logic          e_md_start;
    logic [RW-1:0] m_r_new, m_r_use2;
    logic [TW-1:0] m_t_new;
    logic [RW-1:0] w_r_new;
    logic [TW-1:0] w_t_new;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic hit(input logic [RW-1:0] src, input logic [RW-1:0] dst);
        return (src != '0) && (dst == src);
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Nearest producer wins; a newer producer that is not ready yet masks older ready ones.
    function automatic logic [1:0] sel_d(input logic [RW-1:0] src,
                                         input logic [RW-1:0] e_rn, input logic [TW-1:0] e_tn,
                                         input logic [RW-1:0] m_rn, input logic [TW-1:0] m_tn,
                                         input logic [RW-1:0] w_rn, input logic [TW-1:0] w_tn);
        if (hit(src, e_rn)) return (e_tn == '0) ? 2'd1 : 2'd0;
        if (hit(src, m_rn)) return (m_tn == '0) ? 2'd2 : 2'd0;
        if (hit(src, w_rn)) return (w_tn == '0) ? 2'd3 : 2'd0;
        return 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [RW-1:0] src,
                                         input logic [RW-1:0] m_rn, input logic [TW-1:0] m_tn,
                                         input logic [RW-1:0] w_rn, input logic [TW-1:0] w_tn);
        if (hit(src, m_rn)) return (m_tn == '0) ? 2'd2 : 2'd0;
        if (hit(src, w_rn)) return (w_tn == '0) ? 2'd3 : 2'd0;
        return 2'd0;
    endfunction

    // Shadow pipeline: M/W always advance so hazards drain; E takes a bubble while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r_new    <= '0;
            e_r_use1   <= '0;
            e_r_use2   <= '0;
            e_t_new    <= '0;
            e_md_start <= 1'b0;
            m_r_new    <= '0;
            m_r_use2   <= '0;
            m_t_new    <= '0;
            w_r_new    <= '0;
            w_t_new    <= '0;
        end else begin
            m_r_new  <= e_r_new;
            m_r_use2 <= e_r_use2;
            m_t_new  <= dec_sat(e_t_new);
            w_r_new  <= m_r_new;
            w_t_new  <= dec_sat(m_t_new);
            if (stall) begin
                e_r_new    <= '0;
                e_r_use1   <= '0;
                e_r_use2   <= '0;
                e_t_new    <= '0;
                e_md_start <= 1'b0;
            end else begin
                e_r_new    <= d_r_new;
                e_r_use1   <= d_r_use1;
                e_r_use2   <= d_r_use2;
                e_t_new    <= d_t_new;
                e_md_start <= d_md_start;
            end
        end
    end

    // Stall when a producer's result arrives later than the D instruction needs it,
    // or when HI/LO is occupied by a running or just-issued mult/div.
    always_comb begin
        stall = 1'b0;
        if (hit(d_r_use1, e_r_new) && (e_t_new > d_t_use1)) stall = 1'b1;
        if (hit(d_r_use1, m_r_new) && (m_t_new > d_t_use1)) stall = 1'b1;
        if (hit(d_r_use1, w_r_new) && (w_t_new > d_t_use1)) stall = 1'b1;
        if (hit(d_r_use2, e_r_new) && (e_t_new > d_t_use2)) stall = 1'b1;
        if (hit(d_r_use2, m_r_new) && (m_t_new > d_t_use2)) stall = 1'b1;
        if (hit(d_r_use2, w_r_new) && (w_t_new > d_t_use2)) stall = 1'b1;
        if (d_md && (md_busy || e_md_start)) stall = 1'b1;
    end

    assign flush_e = stall;

    // Forwarding selects for the D, E and M operand muxes.
    always_comb begin
        fwd_d1 = sel_d(d_r_use1, e_r_new, e_t_new, m_r_new, m_t_new, w_r_new, w_t_new);
        fwd_d2 = sel_d(d_r_use2, e_r_new, e_t_new, m_r_new, m_t_new, w_r_new, w_t_new);
        fwd_e1 = sel_e(e_r_use1, m_r_new, m_t_new, w_r_new, w_t_new);
        fwd_e2 = sel_e(e_r_use2, m_r_new, m_t_new, w_r_new, w_t_new);
        fwd_m2 = hit(m_r_use2, w_r_new) && (w_t_new == '0);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a history-based model checked every cycle,
// plus literal expectations on directed hazard scenarios.
module tb_hazard_ctrl;

    localparam int unsigned TW = 2;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [RW-1:0] d_r_new, d_r_use1, d_r_use2;
    logic [TW-1:0] d_t_new, d_t_use1, d_t_use2;
    logic          d_md, d_md_start, md_busy;
    logic          stall, flush_e, fwd_m2;
    logic [1:0]    fwd_d1, fwd_d2, fwd_e1, fwd_e2;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    hazard_ctrl #(.TW(TW), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_r_new    (d_r_new),
        .d_r_use1   (d_r_use1),
        .d_r_use2   (d_r_use2),
        .d_t_new    (d_t_new),
        .d_t_use1   (d_t_use1),
        .d_t_use2   (d_t_use2),
        .d_md       (d_md),
        .d_md_start (d_md_start),
        .md_busy    (md_busy),
        .stall      (stall),
        .flush_e    (flush_e),
        .fwd_d1     (fwd_d1),
        .fwd_d2     (fwd_d2),
        .fwd_e1     (fwd_e1),
        .fwd_e2     (fwd_e2),
        .fwd_m2     (fwd_m2)
    );

    always #5 clk = ~clk;

    // Model history: slot a holds the instruction that entered E a cycles ago
    // (0 = in E, 1 = in M, 2 = in W). t_new is kept as issued; age gives what remains.
    int h_rn[3] = '{0, 0, 0};
    int h_tn[3] = '{0, 0, 0};
    int h_u1[3] = '{0, 0, 0};
    int h_u2[3] = '{0, 0, 0};
    int h_md[3] = '{0, 0, 0};

    function automatic int left(int age);
        return (h_tn[age] > age) ? h_tn[age] - age : 0;
    endfunction

    function automatic bit prod(int age, int r);
        return (r != 0) && (h_rn[age] == r);
    endfunction

    function automatic bit m_stall();
        int ur[2];
        int ut[2];
        ur = '{int'(d_r_use1), int'(d_r_use2)};
        ut = '{int'(d_t_use1), int'(d_t_use2)};
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 3; a++)
                if (prod(a, ur[k]) && left(a) > ut[k]) return 1'b1;
        return d_md && (md_busy || h_md[0] != 0);
    endfunction

    // Select code for the nearest producer at or beyond age 'first'; code is age + 1.
    function automatic int m_fwd(int r, int first);
        for (int a = first; a < 3; a++)
            if (prod(a, r)) return (left(a) == 0) ? a + 1 : 0;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model advance: history shifts every cycle; a stalled D becomes a bubble.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 3; a++) begin
                h_rn[a] <= 0; h_tn[a] <= 0; h_u1[a] <= 0; h_u2[a] <= 0; h_md[a] <= 0;
            end
        end else begin
            for (int a = 2; a > 0; a--) begin
                h_rn[a] <= h_rn[a-1]; h_tn[a] <= h_tn[a-1];
                h_u1[a] <= h_u1[a-1]; h_u2[a] <= h_u2[a-1]; h_md[a] <= h_md[a-1];
            end
            if (m_stall()) begin
                h_rn[0] <= 0; h_tn[0] <= 0; h_u1[0] <= 0; h_u2[0] <= 0; h_md[0] <= 0;
            end else begin
                h_rn[0] <= int'(d_r_new);  h_tn[0] <= int'(d_t_new);
                h_u1[0] <= int'(d_r_use1); h_u2[0] <= int'(d_r_use2);
                h_md[0] <= int'(d_md_start);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run) begin
            chk("stall", stall, m_stall());
            chk("flush_e", flush_e, m_stall());
            chk("fwd_d1", fwd_d1, m_fwd(int'(d_r_use1), 0));
            chk("fwd_d2", fwd_d2, m_fwd(int'(d_r_use2), 0));
            chk("fwd_e1", fwd_e1, m_fwd(h_u1[0], 1));
            chk("fwd_e2", fwd_e2, m_fwd(h_u2[0], 1));
            chk("fwd_m2", fwd_m2, prod(2, h_u2[1]) && left(2) == 0);
        end
    end

    task automatic set_d(input int rn, input int u1, input int u2, input int tn,
                         input int tu1, input int tu2, input bit md = 1'b0,
                         input bit mds = 1'b0);
        d_r_new  = RW'(rn);
        d_r_use1 = RW'(u1);
        d_r_use2 = RW'(u2);
        d_t_new  = TW'(tn);
        d_t_use1 = TW'(tu1);
        d_t_use2 = TW'(tu2);
        d_md       = md;
        d_md_start = mds;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        md_busy = 1'b0;
        // Reset held with live inputs: nothing may leak through.
        set_d(9, 5, 6, 1, 0, 0);
        #1 rst_n = 1'b0;
        run = 1'b1;
        to_neg();
        chk("lit_rst_stall", stall, 0);
        chk("lit_rst_fwd_d1", fwd_d1, 0);
        chk("lit_rst_fwd_e1", fwd_e1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        // E now holds {r_new 9, t_new 1}; a t_use 0 reader of $9 must stall.
        set_d(0, 9, 0, 0, 0, 3);
        to_neg();
        chk("lit_first_tuple_stall", stall, 1);
        chk("lit_first_tuple_fwd_d1", fwd_d1, 0);
        tick();
        to_neg();
        chk("lit_first_tuple_drain_stall", stall, 0);
        chk("lit_first_tuple_fwd_d1_m", fwd_d1, 2);
        tick();
        to_neg();
        chk("lit_first_tuple_fwd_e1_w", fwd_e1, 3);

        // ALU back-to-back.
        set_d(3, 1, 2, 1, 1, 1);
        tick();
        set_d(8, 3, 0, 1, 1, 3);
        to_neg();
        chk("lit_alu_stall", stall, 0);
        chk("lit_alu_fwd_d1", fwd_d1, 0);
        tick();
        set_d(0, 0, 0, 0, 3, 3);
        to_neg();
        chk("lit_alu_fwd_e1", fwd_e1, 2);

        // Load-use into a branch.
        set_d(4, 29, 0, 2, 1, 3);
        tick();
        set_d(0, 4, 5, 0, 0, 0);
        to_neg();
        chk("lit_lu_stall1", stall, 1);
        chk("lit_lu_flush1", flush_e, 1);
        tick();
        to_neg();
        chk("lit_lu_stall2", stall, 1);
        tick();
        to_neg();
        chk("lit_lu_stall3", stall, 0);
        chk("lit_lu_fwd_d1", fwd_d1, 3);
        tick();

        // Register 0 never creates a dependency.
        set_d(0, 1, 1, 2, 1, 1);
        tick();
        set_d(6, 0, 0, 1, 0, 0);
        to_neg();
        chk("lit_r0_stall", stall, 0);
        chk("lit_r0_fwd_d1", fwd_d1, 0);
        tick();

        // Newer non-ready producer in E masks a ready one in W.
        set_d(7, 0, 0, 0, 3, 3);
        tick();
        set_d(0, 0, 0, 0, 3, 3);
        tick();
        set_d(7, 0, 0, 1, 3, 3);
        tick();
        set_d(0, 7, 0, 0, 1, 3);
        to_neg();
        chk("lit_np_stall", stall, 0);
        chk("lit_np_fwd_d1", fwd_d1, 0);
        tick();
        set_d(0, 0, 0, 0, 3, 3);
        to_neg();
        chk("lit_np_fwd_e1", fwd_e1, 2);

        // Store data fed by a load: too late for E, caught in M from W.
        set_d(4, 29, 0, 2, 1, 3);
        tick();
        set_d(0, 29, 4, 0, 1, 2);
        to_neg();
        chk("lit_st_stall", stall, 0);
        tick();
        set_d(0, 0, 0, 0, 3, 3);
        to_neg();
        chk("lit_st_fwd_e2", fwd_e2, 0);
        tick();
        to_neg();
        chk("lit_st_fwd_m2", fwd_m2, 1);
        tick();

        // HI/LO access while the mult/div unit is busy.
        md_busy = 1'b1;
        set_d(2, 0, 0, 1, 3, 3, 1'b1, 1'b0);
        to_neg();
        chk("lit_md_busy_stall1", stall, 1);
        tick();
        to_neg();
        chk("lit_md_busy_stall2", stall, 1);
        tick();
        md_busy = 1'b0;
        to_neg();
        chk("lit_md_busy_release", stall, 0);
        tick();
        // mult in E, mflo in D: one bubble.
        set_d(0, 8, 9, 0, 1, 1, 1'b1, 1'b1);
        tick();
        set_d(2, 0, 0, 1, 3, 3, 1'b1, 1'b0);
        to_neg();
        chk("lit_md_e_stall", stall, 1);
        tick();
        to_neg();
        chk("lit_md_e_release", stall, 0);
        tick();

        // Reset mid-hazard discards the shadow state at once.
        set_d(4, 29, 0, 2, 1, 3);
        tick();
        set_d(0, 4, 0, 0, 0, 0);
        to_neg();
        chk("lit_rr_stall_pre", stall, 1);
        #1 rst_n = 1'b0;
        #1 chk("lit_rr_stall_in_reset", stall, 0);
        tick();
        rst_n = 1'b1;
        to_neg();
        chk("lit_rr_stall_post", stall, 0);
        tick();
        set_d(0, 0, 0, 0, 3, 3);
        to_neg();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
